// File: rtl/mfb_mvb_checker_pkg.sv
// ----------------------------------------------------------------------------
// mfb_mvb_checker_pkg
// Shared types and width helpers for the MFB/MVB stream checker.
//   err_code_t      : error code reported on err_code
//   sof_pos_width   : bits of one region's SOF block index
//   eof_pos_width   : bits of one region's EOF item index
//   pair_diff_width : bits of the signed MVB-minus-SOF difference
//   region_width    : bits of a region number (at least 1)
// ----------------------------------------------------------------------------
package mfb_mvb_checker_pkg;

   typedef enum logic [1:0] {
      ERR_NONE          = 2'd0,
      ERR_SOF_IN_FRAME  = 2'd1,
      ERR_EOF_NO_FRAME  = 2'd2,
      ERR_PAIR_OVERFLOW = 2'd3
   } err_code_t;

   function automatic int sof_pos_width(input int region_size);
      return (region_size > 1) ? $clog2(region_size) : 1;
   endfunction

   function automatic int eof_pos_width(input int region_size, input int block_size);
      return (region_size * block_size > 1) ? $clog2(region_size * block_size) : 1;
   endfunction

   // One extra bit so +max_outstanding fits, one more for the sign.
   function automatic int pair_diff_width(input int max_outstanding);
      return $clog2(max_outstanding) + 2;
   endfunction

   function automatic int region_width(input int regions);
      return (regions > 1) ? $clog2(regions) : 1;
   endfunction

endpackage

// File: rtl/mfb_region_frame_step.sv
// ----------------------------------------------------------------------------
// mfb_region_frame_step
// Combinational frame-state step for one MFB region. Chained across the
// regions of a word, carrying the frame-open flag from region to region.
// Ports:
//   f_in    in  frame open on entry to this region
//   sof     in  start of frame in this region (already gated by acceptance)
//   eof     in  end of frame in this region (already gated by acceptance)
//   sof_pos in  SOF block index inside the region
//   eof_pos in  EOF item index inside the region
//   f_out   out frame open on exit from this region
//   err     out framing violation in this region
//   code    out violation code (ERR_NONE when err=0)
// ----------------------------------------------------------------------------
module mfb_region_frame_step
   import mfb_mvb_checker_pkg::*;
#(
   parameter int REGION_SIZE = 8,
   parameter int BLOCK_SIZE  = 8
)(
   input  logic                                              f_in,
   input  logic                                              sof,
   input  logic                                              eof,
   input  logic [sof_pos_width(REGION_SIZE)-1:0]             sof_pos,
   input  logic [eof_pos_width(REGION_SIZE, BLOCK_SIZE)-1:0] eof_pos,
   output logic                                              f_out,
   output logic                                              err,
   output err_code_t                                         code
);

   localparam int EOF_W  = eof_pos_width(REGION_SIZE, BLOCK_SIZE);
   localparam int BLK_SH = $clog2(BLOCK_SIZE);

   // SOF position converted from blocks to items so it compares with eof_pos.
   logic [EOF_W-1:0] sof_item;
   assign sof_item = EOF_W'(sof_pos) << BLK_SH;

   always_comb begin
      f_out = f_in;
      err   = 1'b0;
      code  = ERR_NONE;
      case ({sof, eof})
         2'b10: begin
            if (f_in) begin
               err  = 1'b1;
               code = ERR_SOF_IN_FRAME;
            end
            f_out = 1'b1;
         end
         2'b01: begin
            if (!f_in) begin
               err  = 1'b1;
               code = ERR_EOF_NO_FRAME;
            end
            f_out = 1'b0;
         end
         2'b11: begin
            if (!f_in) begin
               // Idle on entry: only a whole frame inside the region is legal.
               if (eof_pos >= sof_item) begin
                  f_out = 1'b0;
               end else begin
                  err   = 1'b1;
                  code  = ERR_EOF_NO_FRAME;
                  f_out = 1'b1;
               end
            end else begin
               // Open on entry: the EOF must close it before the new SOF.
               if (eof_pos < sof_item) begin
                  f_out = 1'b1;
               end else begin
                  err   = 1'b1;
                  code  = ERR_SOF_IN_FRAME;
                  f_out = 1'b0;
               end
            end
         end
         default: begin
            f_out = f_in;
         end
      endcase
   end

endmodule

// File: rtl/mfb_mvb_stream_checker.sv
// ----------------------------------------------------------------------------
// mfb_mvb_stream_checker
// Passive checker for a paired MFB frame stream and MVB metadata stream.
// Walks the regions of each accepted MFB word to track frame-open state,
// counts MVB items against MFB SOFs, and reports the first violation of each
// cycle as a registered error with a sticky flag.
// Optional build macro: MFB_MVB_CHECKER_STATS_EN adds stat_frames/stat_errors.
// Ports:
//   clk          in  clock
//   reset        in  synchronous active-high reset
//   mfb_sof      in  per-region start of frame
//   mfb_eof      in  per-region end of frame
//   mfb_sof_pos  in  per-region SOF block index
//   mfb_eof_pos  in  per-region EOF item index
//   mfb_src_rdy  in  MFB valid
//   mfb_dst_rdy  in  MFB ready (observed only)
//   mvb_vld      in  per-item MVB valid
//   mvb_src_rdy  in  MVB valid
//   mvb_dst_rdy  in  MVB ready (observed only)
//   err_vld      out one-cycle error pulse
//   err_code     out code of the reported violation (held while err_vld=0)
//   err_region   out region of the reported violation (0 for pair overflow)
//   err_sticky   out set by any error, cleared by reset
//   pair_diff    out signed MVB items minus MFB SOFs, clamped
//   in_frame     out frame open after the last accepted word
//   stat_frames  out legally completed frames, saturating (stats build only)
//   stat_errors  out error cycles, saturating (stats build only)
// ----------------------------------------------------------------------------
module mfb_mvb_stream_checker
   import mfb_mvb_checker_pkg::*;
#(
   parameter int REGIONS         = 4,
   parameter int REGION_SIZE     = 8,
   parameter int BLOCK_SIZE      = 8,
   parameter int MVB_ITEMS       = 4,
   parameter int MAX_OUTSTANDING = 16
)(
   input  logic                                                      clk,
   input  logic                                                      reset,
   input  logic [REGIONS-1:0]                                        mfb_sof,
   input  logic [REGIONS-1:0]                                        mfb_eof,
   input  logic [REGIONS*sof_pos_width(REGION_SIZE)-1:0]             mfb_sof_pos,
   input  logic [REGIONS*eof_pos_width(REGION_SIZE, BLOCK_SIZE)-1:0] mfb_eof_pos,
   input  logic                                                      mfb_src_rdy,
   input  logic                                                      mfb_dst_rdy,
   input  logic [MVB_ITEMS-1:0]                                      mvb_vld,
   input  logic                                                      mvb_src_rdy,
   input  logic                                                      mvb_dst_rdy,
   output logic                                                      err_vld,
   output logic [1:0]                                                err_code,
   output logic [region_width(REGIONS)-1:0]                          err_region,
   output logic                                                      err_sticky,
   output logic [pair_diff_width(MAX_OUTSTANDING)-1:0]               pair_diff,
   output logic                                                      in_frame
`ifdef MFB_MVB_CHECKER_STATS_EN
   ,
   output logic [31:0]                                               stat_frames,
   output logic [15:0]                                               stat_errors
`endif
);

   localparam int SOF_W = sof_pos_width(REGION_SIZE);
   localparam int EOF_W = eof_pos_width(REGION_SIZE, BLOCK_SIZE);
   localparam int PD_W  = pair_diff_width(MAX_OUTSTANDING);
   localparam int RG_W  = region_width(REGIONS);
   localparam int CNT_W = $clog2(((MVB_ITEMS > REGIONS) ? MVB_ITEMS : REGIONS) + 1);
   localparam int SUM_W = PD_W + CNT_W + 1;

   localparam logic signed [SUM_W-1:0] LIMIT = SUM_W'(MAX_OUTSTANDING);

   // ---------------------------------------------------------------- state
   logic                    err_vld_reg;
   err_code_t               err_code_reg;
   logic [RG_W-1:0]         err_region_reg;
   logic                    err_sticky_reg;
   logic signed [PD_W-1:0]  pair_diff_reg;
   logic                    in_frame_reg;

   // ------------------------------------------------------------ acceptance
   logic                    mfb_acc;
   logic                    mvb_acc;
   logic [REGIONS-1:0]      sof_acc;
   logic [REGIONS-1:0]      eof_acc;

   assign mfb_acc = mfb_src_rdy & mfb_dst_rdy;
   assign mvb_acc = mvb_src_rdy & mvb_dst_rdy;
   // Gating here makes an idle cycle a pass-through for the region chain.
   assign sof_acc = mfb_sof & {REGIONS{mfb_acc}};
   assign eof_acc = mfb_eof & {REGIONS{mfb_acc}};

   // ----------------------------------------------------------- region walk
   logic [REGIONS:0]        f_chain;
   logic [REGIONS-1:0]      step_err;
   err_code_t               step_code [REGIONS];

   assign f_chain[0] = in_frame_reg;

   generate
      for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
         mfb_region_frame_step #(
            .REGION_SIZE (REGION_SIZE),
            .BLOCK_SIZE  (BLOCK_SIZE)
         ) u_step (
            .f_in    (f_chain[gi]),
            .sof     (sof_acc[gi]),
            .eof     (eof_acc[gi]),
            .sof_pos (mfb_sof_pos[gi*SOF_W +: SOF_W]),
            .eof_pos (mfb_eof_pos[gi*EOF_W +: EOF_W]),
            .f_out   (f_chain[gi+1]),
            .err     (step_err[gi]),
            .code    (step_code[gi])
         );
      end
   endgenerate

   // Lowest-region framing error wins; scanning downward lets it overwrite.
   logic                    frame_err;
   err_code_t               frame_code;
   logic [RG_W-1:0]         frame_region;

   always_comb begin
      frame_err    = |step_err;
      frame_code   = ERR_NONE;
      frame_region = '0;
      for (int i = REGIONS - 1; i >= 0; i--) begin
         if (step_err[i]) begin
            frame_code   = step_code[i];
            frame_region = RG_W'(i);
         end
      end
   end

   // --------------------------------------------------------------- pairing
   logic [CNT_W-1:0]        mvb_cnt;
   logic [CNT_W-1:0]        sof_cnt;
   logic signed [SUM_W-1:0] pair_sum;
   logic signed [PD_W-1:0]  pair_diff_next;
   logic                    pair_ovf;

   always_comb begin
      mvb_cnt = '0;
      for (int i = 0; i < MVB_ITEMS; i++) begin
         mvb_cnt = mvb_cnt + CNT_W'(mvb_vld[i] & mvb_acc);
      end
      sof_cnt = '0;
      for (int i = 0; i < REGIONS; i++) begin
         sof_cnt = sof_cnt + CNT_W'(sof_acc[i]);
      end
   end

   always_comb begin
      pair_sum = SUM_W'(pair_diff_reg)
               + $signed(SUM_W'(mvb_cnt))
               - $signed(SUM_W'(sof_cnt));
      pair_ovf = 1'b0;
      if (pair_sum > LIMIT) begin
         pair_ovf       = 1'b1;
         pair_diff_next = PD_W'(MAX_OUTSTANDING);
      end else if (pair_sum < -LIMIT) begin
         pair_ovf       = 1'b1;
         pair_diff_next = PD_W'(-MAX_OUTSTANDING);
      end else begin
         pair_diff_next = pair_sum[PD_W-1:0];
      end
   end

   // ------------------------------------------------------------- reporting
   logic                    err_vld_next;
   err_code_t               err_code_next;
   logic [RG_W-1:0]         err_region_next;

   always_comb begin
      err_vld_next    = frame_err | pair_ovf;
      err_code_next   = err_code_reg;
      err_region_next = err_region_reg;
      if (frame_err) begin
         err_code_next   = frame_code;
         err_region_next = frame_region;
      end else if (pair_ovf) begin
         err_code_next   = ERR_PAIR_OVERFLOW;
         err_region_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_vld_reg    <= 1'b0;
         err_code_reg   <= ERR_NONE;
         err_region_reg <= '0;
         err_sticky_reg <= 1'b0;
         pair_diff_reg  <= '0;
         in_frame_reg   <= 1'b0;
      end else begin
         err_vld_reg    <= err_vld_next;
         err_code_reg   <= err_code_next;
         err_region_reg <= err_region_next;
         err_sticky_reg <= err_sticky_reg | err_vld_next;
         pair_diff_reg  <= pair_diff_next;
         in_frame_reg   <= f_chain[REGIONS];
      end
   end

   assign err_vld    = err_vld_reg;
   assign err_code   = err_code_reg;
   assign err_region = err_region_reg;
   assign err_sticky = err_sticky_reg;
   assign pair_diff  = pair_diff_reg;
   assign in_frame   = in_frame_reg;

`ifdef MFB_MVB_CHECKER_STATS_EN
   // ------------------------------------------------------------ statistics
   localparam int DONE_W = $clog2(REGIONS + 1);

   logic [31:0]             stat_frames_reg;
   logic [31:0]             stat_frames_next;
   logic [15:0]             stat_errors_reg;
   logic [15:0]             stat_errors_next;
   logic [DONE_W-1:0]       done_cnt;
   logic [32:0]             frames_sum;

   // An EOF that raised no error in its region completed a frame legally.
   always_comb begin
      done_cnt = '0;
      for (int i = 0; i < REGIONS; i++) begin
         done_cnt = done_cnt + DONE_W'(eof_acc[i] & ~step_err[i]);
      end
      frames_sum       = {1'b0, stat_frames_reg} + 33'(done_cnt);
      stat_frames_next = frames_sum[32] ? '1 : frames_sum[31:0];
      stat_errors_next = stat_errors_reg;
      if (err_vld_next && (stat_errors_reg != '1)) begin
         stat_errors_next = stat_errors_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_frames_reg <= '0;
         stat_errors_reg <= '0;
      end else begin
         stat_frames_reg <= stat_frames_next;
         stat_errors_reg <= stat_errors_next;
      end
   end

   assign stat_frames = stat_frames_reg;
   assign stat_errors = stat_errors_reg;
`endif

endmodule

// File: tb/tb_mfb_mvb_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_mfb_mvb_stream_checker
// Directed, table-driven bench for mfb_mvb_stream_checker with default
// parameters (4 regions, 8 blocks x 8 items, 4 MVB items, limit 16).
// ----------------------------------------------------------------------------
module tb_mfb_mvb_stream_checker;

   logic        clk;
   logic        reset;
   logic [3:0]  mfb_sof;
   logic [3:0]  mfb_eof;
   logic [11:0] mfb_sof_pos;
   logic [23:0] mfb_eof_pos;
   logic        mfb_src_rdy;
   logic        mfb_dst_rdy;
   logic [3:0]  mvb_vld;
   logic        mvb_src_rdy;
   logic        mvb_dst_rdy;
   logic        err_vld;
   logic [1:0]  err_code;
   logic [1:0]  err_region;
   logic        err_sticky;
   logic [5:0]  pair_diff;
   logic        in_frame;
`ifdef MFB_MVB_CHECKER_STATS_EN
   logic [31:0] stat_frames;
   logic [15:0] stat_errors;
`endif

   mfb_mvb_stream_checker dut (
      .clk         (clk),
      .reset       (reset),
      .mfb_sof     (mfb_sof),
      .mfb_eof     (mfb_eof),
      .mfb_sof_pos (mfb_sof_pos),
      .mfb_eof_pos (mfb_eof_pos),
      .mfb_src_rdy (mfb_src_rdy),
      .mfb_dst_rdy (mfb_dst_rdy),
      .mvb_vld     (mvb_vld),
      .mvb_src_rdy (mvb_src_rdy),
      .mvb_dst_rdy (mvb_dst_rdy),
      .err_vld     (err_vld),
      .err_code    (err_code),
      .err_region  (err_region),
      .err_sticky  (err_sticky),
      .pair_diff   (pair_diff),
      .in_frame    (in_frame)
`ifdef MFB_MVB_CHECKER_STATS_EN
      ,
      .stat_frames (stat_frames),
      .stat_errors (stat_errors)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  sof;
      logic [3:0]  eof;
      logic [11:0] sp;
      logic [23:0] ep;
      logic        msrc;
      logic        mdst;
      logic [3:0]  vld;
      logic        vsrc;
      logic        vdst;
      int          evld;
      int          ecode;
      int          ereg;
      int          estk;
      int          epd;
      int          einf;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [11:0] sp(input int r, input int v);
      logic [11:0] x;
      x = '0;
      x[r*3 +: 3] = v[2:0];
      return x;
   endfunction

   function automatic logic [23:0] ep(input int r, input int v);
      logic [23:0] x;
      x = '0;
      x[r*6 +: 6] = v[5:0];
      return x;
   endfunction

   function automatic vec_t mk(input int rst, input int sof, input int eof,
                               input logic [11:0] spv, input logic [23:0] epv,
                               input int msrc, input int mdst, input int vld,
                               input int vsrc, input int vdst,
                               input int evld, input int ecode, input int ereg,
                               input int estk, input int epd, input int einf);
      vec_t v;
      v.rst = rst[0];  v.sof = sof[3:0];  v.eof = eof[3:0];
      v.sp = spv;      v.ep = epv;
      v.msrc = msrc[0]; v.mdst = mdst[0];
      v.vld = vld[3:0]; v.vsrc = vsrc[0]; v.vdst = vdst[0];
      v.evld = evld; v.ecode = ecode; v.ereg = ereg;
      v.estk = estk; v.epd = epd; v.einf = einf;
      return v;
   endfunction

   task automatic check(input string name, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
      end
   endtask

   task automatic check_all(input int row, input int evld, input int ecode, input int ereg,
                            input int estk, input int epd, input int einf);
      check("err_vld",    row, int'(err_vld),            evld);
      check("err_code",   row, int'(err_code),           ecode);
      check("err_region", row, int'(err_region),         ereg);
      check("err_sticky", row, int'(err_sticky),         estk);
      check("pair_diff",  row, int'($signed(pair_diff)), epd);
      check("in_frame",   row, int'(in_frame),           einf);
   endtask

   task automatic set_idle();
      reset = 1'b0;
      mfb_sof = '0; mfb_eof = '0; mfb_sof_pos = '0; mfb_eof_pos = '0;
      mfb_src_rdy = 1'b0; mfb_dst_rdy = 1'b0;
      mvb_vld = '0; mvb_src_rdy = 1'b0; mvb_dst_rdy = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      reset = v.rst;
      mfb_sof = v.sof; mfb_eof = v.eof; mfb_sof_pos = v.sp; mfb_eof_pos = v.ep;
      mfb_src_rdy = v.msrc; mfb_dst_rdy = v.mdst;
      mvb_vld = v.vld; mvb_src_rdy = v.vsrc; mvb_dst_rdy = v.vdst;
      @(posedge clk);
      #1;
      $display("row %0d rst=%0d sof=%b eof=%b vld=%b -> err_vld=%0d code=%0d region=%0d sticky=%0d pd=%0d in_frame=%0d",
               idx, v.rst, v.sof, v.eof, v.vld, err_vld, err_code, err_region,
               err_sticky, $signed(pair_diff), in_frame);
      check_all(idx, v.evld, v.ecode, v.ereg, v.estk, v.epd, v.einf);
   endtask

   initial begin
      set_idle();
      reset = 1'b1;

      // rst sof eof sp ep msrc mdst vld vsrc vdst | evld code reg stk pd inf
      tbl.push_back(mk(1, 0, 0, sp(0,0), ep(0,0), 0,0, 0,0,0,  0,0,0,0, 0,0));
      // frame from region 0 SOF to region 3 EOF of the next word
      tbl.push_back(mk(0, 4'b0001, 0, sp(0,0), ep(0,0), 1,1, 0,0,0,  0,0,0,0,-1,1));
      tbl.push_back(mk(0, 0, 4'b1000, sp(0,0), ep(3,63), 1,1, 0,0,0,  0,0,0,0,-1,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b0001,1,1,  0,0,0,0, 0,0));
      // open a frame while an MVB item arrives in the same cycle
      tbl.push_back(mk(0, 4'b0001, 0, sp(0,0), ep(0,0), 1,1, 4'b0001,1,1,  0,0,0,0, 0,1));
      // close and reopen in region 1: EOF item 5 before SOF item 16
      tbl.push_back(mk(0, 4'b0010, 4'b0010, sp(1,2), ep(1,5), 1,1, 0,0,0,  0,0,0,0,-1,1));
      // SOF item 0 before EOF item 5 while open: SOF in frame, region 1
      tbl.push_back(mk(0, 4'b0010, 4'b0010, sp(1,0), ep(1,5), 1,1, 0,0,0,  1,1,1,1,-2,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 0,0,0,  0,1,1,1,-2,0));
      // EOF with no frame open, region 2
      tbl.push_back(mk(0, 0, 4'b0100, sp(0,0), ep(2,0), 1,1, 0,0,0,  1,2,2,1,-2,0));
      // two errors in one word: region 1 EOF (code 2) reported over region 3 SOF
      tbl.push_back(mk(0, 4'b1100, 4'b0010, sp(0,0), ep(1,9), 1,1, 0,0,0,  1,2,1,1,-4,1));
      // backpressure: everything ignored
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(0, 4'b1111, 4'b1111, sp(0,0), ep(0,0), 1,0, 0,0,0,  0,2,1,1,-4,1));
      tbl.push_back(mk(0, 0, 4'b0001, sp(0,0), ep(0,7), 1,1, 0,0,0,  0,2,1,1,-4,0));
      // single frame in region 2 with EOF exactly at the SOF item (8 >= 8)
      tbl.push_back(mk(0, 4'b0100, 4'b0100, sp(2,1), ep(2,8), 1,1, 0,0,0,  0,2,1,1,-5,0));
      // EOF item 7 before SOF item 8 while idle: EOF no frame, region 3, frame opens
      tbl.push_back(mk(0, 4'b1000, 4'b1000, sp(3,1), ep(3,7), 1,1, 0,0,0,  1,2,3,1,-6,1));
      tbl.push_back(mk(0, 0, 4'b0001, sp(0,0), ep(0,0), 1,1, 0,0,0,  0,2,3,1,-6,0));
      // MVB backpressure, then accepted MVB words
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b1111,1,0,  0,2,3,1,-6,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b1111,1,1,  0,2,3,1,-2,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b0011,1,1,  0,2,3,1, 0,0));
      // pairing: count up to the limit, then overflow and clamp
      for (int k = 1; k <= 16; k++)
         tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b0001,1,1,  0,2,3,1, k,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 4'b0001,1,1,  1,3,0,1,16,0));
      tbl.push_back(mk(0, 0, 0, sp(0,0), ep(0,0), 0,0, 0,0,0,  0,3,0,1,16,0));
      // overflow and framing error together: framing error is reported
      tbl.push_back(mk(0, 0, 4'b0100, sp(0,0), ep(2,3), 1,1, 4'b0001,1,1,  1,2,2,1,16,0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Reset mid-frame, with traffic presented during the reset cycle.
      @(negedge clk);
      set_idle();
      mfb_sof = 4'b0001; mfb_src_rdy = 1'b1; mfb_dst_rdy = 1'b1;
      @(posedge clk); #1;
      $display("seq reset-open -> in_frame=%0d pd=%0d", in_frame, $signed(pair_diff));
      check("open_in_frame", 100, int'(in_frame), 1);
      check("open_pair_diff", 100, int'($signed(pair_diff)), 15);

      @(negedge clk);
      reset = 1'b1;
      mfb_sof = 4'b1111;
      mvb_vld = 4'b1111; mvb_src_rdy = 1'b1; mvb_dst_rdy = 1'b1;
      @(posedge clk); #1;
      $display("seq reset-edge -> err_vld=%0d code=%0d sticky=%0d pd=%0d in_frame=%0d",
               err_vld, err_code, err_sticky, $signed(pair_diff), in_frame);
      check_all(101, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      set_idle();
      mfb_eof = 4'b0001; mfb_src_rdy = 1'b1; mfb_dst_rdy = 1'b1;
      #1;
      check("pre_edge_err_vld", 102, int'(err_vld), 0);
      @(posedge clk); #1;
      $display("seq reset-eof -> err_vld=%0d code=%0d region=%0d sticky=%0d",
               err_vld, err_code, err_region, err_sticky);
      check_all(103, 1, 2, 0, 1, 0, 0);

      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
      $display("seq reset-idle -> err_vld=%0d code=%0d sticky=%0d", err_vld, err_code, err_sticky);
      check_all(104, 0, 2, 0, 1, 0, 0);

      // Negative clamp: four legal single frames per word, 4 SOFs each.
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         set_idle();
         mfb_sof = 4'b1111; mfb_eof = 4'b1111;
         mfb_sof_pos = '0; mfb_eof_pos = 24'hFFFFFF;
         mfb_src_rdy = 1'b1; mfb_dst_rdy = 1'b1;
         @(posedge clk); #1;
         $display("seq neg-clamp %0d -> err_vld=%0d code=%0d region=%0d pd=%0d in_frame=%0d",
                  k, err_vld, err_code, err_region, $signed(pair_diff), in_frame);
         if (k < 5) check_all(104 + k, 0, 2, 0, 1, -4 * k, 0);
         else       check_all(104 + k, 1, 3, 0, 1, -16, 0);
      end

      @(negedge clk);
      set_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
